// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for the async FIFO pointer logic.
// Helpers work on a 32-bit word; callers zero-extend and truncate to their pointer width.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_ADDR_WIDTH  = 5;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int PTR_MAX_W           = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended Gray input keeps the upper bits zero, so truncation stays exact.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchronizer bringing a Gray-coded write pointer into the rclk domain.
module fifo_ptr_sync #(
    parameter int WIDTH       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             rclk,
    input  logic             hw_rst_n,
    input  logic [WIDTH-1:0] async_ptr,
    output logic [WIDTH-1:0] sync_ptr
);

    logic [WIDTH-1:0] stages [SYNC_STAGES];

    // NOTE: only the hardware reset clears these flops; a soft reset must not drop
    // a pointer that is still crossing, so the chain keeps sampling through it.
    always_ff @(posedge rclk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= async_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign sync_ptr = stages[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: read pointer, read data register, flags and level.
// Define FIFO_UNDERFLOW_STICKY_EN to hold underflow high until the next reset.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                  rclk,
    input  logic                  hw_rst_n,
    input  logic                  sw_rst,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] aempty_value,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  rdempty,
    output logic                  rd_almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   fifo_read_count,
    output logic [ADDR_WIDTH:0]   rd_level
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] wptr_sync;
    logic [PTR_W-1:0] wbin_sync;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] rgray_next;
    logic [PTR_W-1:0] level_next;
    logic             accept;
    logic             rejected;
    logic             empty_next;
    logic             aempty_next;
    logic             underflow_next;

    fifo_ptr_sync #(
        .WIDTH       (PTR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .rclk      (rclk),
        .hw_rst_n  (hw_rst_n),
        .async_ptr (wptr_gray),
        .sync_ptr  (wptr_sync)
    );

    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        accept      = read_enable & ~rdempty;
        rejected    = read_enable & rdempty;
        rbin_next   = rbin + PTR_W'(accept);
        rgray_next  = PTR_W'(bin2gray(ptr_word_t'(rbin_next)));
        wbin_sync   = PTR_W'(gray2bin(ptr_word_t'(wptr_sync)));
        level_next  = wbin_sync - rbin_next;
        empty_next  = (rgray_next == wptr_sync);
        aempty_next = (level_next <= PTR_W'(aempty_value));
    end

`ifdef FIFO_UNDERFLOW_STICKY_EN
    assign underflow_next = underflow | rejected;
`else
    assign underflow_next = rejected;
`endif

    // Soft reset clears everything the hardware reset does except the synchronizer.
    always_ff @(posedge rclk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            rbin            <= '0;
            rptr_gray       <= '0;
            read_data       <= '0;
            fifo_read_count <= '0;
            rd_level        <= '0;
            rdempty         <= 1'b1;
            rd_almost_empty <= 1'b1;
            underflow       <= 1'b0;
        end else if (sw_rst) begin
            rbin            <= '0;
            rptr_gray       <= '0;
            read_data       <= '0;
            fifo_read_count <= '0;
            rd_level        <= '0;
            rdempty         <= 1'b1;
            rd_almost_empty <= 1'b1;
            underflow       <= 1'b0;
        end else begin
            rbin            <= rbin_next;
            rptr_gray       <= rgray_next;
            rd_level        <= level_next;
            rdempty         <= empty_next;
            rd_almost_empty <= aempty_next;
            underflow       <= underflow_next;
            if (accept) begin
                read_data       <= mem_rdata;
                fifo_read_count <= fifo_read_count + PTR_W'(1);
            end
        end
    end

    assign mem_raddr = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios plus a randomized run against a count-based model.
module tb_fifo_rd_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int SS    = 2;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 1 << PW;
`ifdef FIFO_UNDERFLOW_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          rclk = 1'b0;
    logic          hw_rst_n;
    logic          sw_rst;
    logic          read_enable;
    logic [AW-1:0] aempty_value;
    logic [PW-1:0] wptr_gray;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_raddr;
    logic [PW-1:0] rptr_gray;
    logic [DW-1:0] read_data;
    logic          rdempty;
    logic          rd_almost_empty;
    logic          underflow;
    logic [PW-1:0] fifo_read_count;
    logic [PW-1:0] rd_level;

    logic [DW-1:0] mem [DEPTH];
    int            checks = 0;
    int            errors = 0;
    int            wcount = 0;

    // Reference model: counts of writes and reads, with writes seen SS edges late.
    int            hist[$] = '{0, 0};
    logic [DW-1:0] exp_q[$];
    int            seen_w;
    int            m_rptr  = 0;
    int            m_level = 0;
    int            m_total = 0;
    bit            m_empty = 1'b1;
    bit            m_aempty = 1'b1;
    bit            m_underflow = 1'b0;
    bit            m_rej;
    logic [DW-1:0] m_rdata = '0;

    assign mem_rdata = mem[mem_raddr];

    always #5 rclk = ~rclk;

    fifo_rd_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS)
    ) dut (
        .rclk            (rclk),
        .hw_rst_n        (hw_rst_n),
        .sw_rst          (sw_rst),
        .read_enable     (read_enable),
        .aempty_value    (aempty_value),
        .wptr_gray       (wptr_gray),
        .mem_rdata       (mem_rdata),
        .mem_raddr       (mem_raddr),
        .rptr_gray       (rptr_gray),
        .read_data       (read_data),
        .rdempty         (rdempty),
        .rd_almost_empty (rd_almost_empty),
        .underflow       (underflow),
        .fifo_read_count (fifo_read_count),
        .rd_level        (rd_level)
    );

    function automatic int gray_of(input int v);
        return (v ^ (v >> 1)) & (PMOD - 1);
    endfunction

    always @(posedge rclk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            m_rptr = 0; m_level = 0; m_total = 0; m_empty = 1'b1; m_aempty = 1'b1;
            m_underflow = 1'b0; m_rdata = '0;
            exp_q.delete();
            hist = '{0, 0};
        end else begin
            seen_w = hist[0];
            if (sw_rst) begin
                m_rptr = 0; m_level = 0; m_empty = 1'b1; m_aempty = 1'b1;
                m_underflow = 1'b0; m_rdata = '0;
                exp_q.delete();
            end else begin
                m_rej = read_enable && m_empty;
                if (read_enable && !m_empty) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL model_pop read accepted with no queued data");
                    end else begin
                        m_rdata = exp_q.pop_front();
                    end
                    m_rptr = (m_rptr + 1) % PMOD;
                    m_total++;
                end
                m_level  = (seen_w - m_rptr + PMOD) % PMOD;
                m_empty  = (m_level == 0);
                m_aempty = (m_level <= int'(aempty_value));
                m_underflow = STICKY ? (m_underflow || m_rej) : m_rej;
            end
            hist.push_back(wcount);
            void'(hist.pop_front());
        end
    end

    task automatic tick();
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic push_write();
        logic [DW-1:0] d;
        d = $urandom;
        mem[wcount % DEPTH] = d;
        exp_q.push_back(d);
        wcount = (wcount + 1) % PMOD;
        wptr_gray = PW'(gray_of(wcount));
    endtask

    task automatic test_reset();
        hw_rst_n = 1'b0; sw_rst = 1'b0; read_enable = 1'b0; aempty_value = 5'd4;
        wcount = 0; wptr_gray = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (2) @(negedge rclk);
        checks++; if (rdempty !== 1'b1) begin errors++; $display("FAIL rst_rdempty got %0h exp 1", rdempty); end
        checks++; if (rd_almost_empty !== 1'b1) begin errors++; $display("FAIL rst_aempty got %0h exp 1", rd_almost_empty); end
        checks++; if (rd_level !== '0) begin errors++; $display("FAIL rst_level got %0h exp 0", rd_level); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst_underflow got %0h exp 0", underflow); end
        checks++; if (fifo_read_count !== '0) begin errors++; $display("FAIL rst_count got %0h exp 0", fifo_read_count); end
        checks++; if (read_data !== '0) begin errors++; $display("FAIL rst_rdata got %0h exp 0", read_data); end
        checks++; if (rptr_gray !== '0) begin errors++; $display("FAIL rst_rptr got %0h exp 0", rptr_gray); end
        hw_rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (rdempty !== 1'b1) begin errors++; $display("FAIL idle_rdempty got %0h exp 1", rdempty); end
        checks++; if (rd_almost_empty !== 1'b1) begin errors++; $display("FAIL idle_aempty got %0h exp 1", rd_almost_empty); end
        checks++; if (rd_level !== '0) begin errors++; $display("FAIL idle_level got %0h exp 0", rd_level); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL idle_underflow got %0h exp 0", underflow); end
    endtask

    task automatic test_basic_read();
        push_write(); tick();
        push_write(); tick();
        checks++; if (rdempty !== 1'b1) begin errors++; $display("FAIL sync_early_empty got %0h exp 1", rdempty); end
        push_write(); tick();
        checks++; if (rdempty !== 1'b0) begin errors++; $display("FAIL sync_empty_clear got %0h exp 0", rdempty); end
        checks++; if (rd_level !== PW'(1)) begin errors++; $display("FAIL sync_level1 got %0d exp 1", rd_level); end
        repeat (2) tick();
        checks++; if (rd_level !== PW'(3)) begin errors++; $display("FAIL basic_level3 got %0d exp 3", rd_level); end
        for (int i = 0; i < 3; i++) begin
            read_enable = 1'b1;
            tick();
            checks++; if (read_data !== mem[i]) begin errors++; $display("FAIL basic_rdata%0d got %0h exp %0h", i, read_data, mem[i]); end
            checks++; if (fifo_read_count !== PW'(i + 1)) begin errors++; $display("FAIL basic_count%0d got %0d exp %0d", i, fifo_read_count, i + 1); end
        end
        read_enable = 1'b0;
        checks++; if (rdempty !== 1'b1) begin errors++; $display("FAIL basic_empty_after got %0h exp 1", rdempty); end
        checks++; if (rd_level !== '0) begin errors++; $display("FAIL basic_level_after got %0d exp 0", rd_level); end
    endtask

    task automatic test_almost_empty();
        aempty_value = 5'd4;
        repeat (6) begin push_write(); tick(); end
        repeat (3) tick();
        checks++; if (rd_level !== PW'(6)) begin errors++; $display("FAIL ae_level6 got %0d exp 6", rd_level); end
        checks++; if (rd_almost_empty !== 1'b0) begin errors++; $display("FAIL ae_at6 got %0h exp 0", rd_almost_empty); end
        read_enable = 1'b1;
        tick();
        checks++; if (rd_level !== PW'(5)) begin errors++; $display("FAIL ae_level5 got %0d exp 5", rd_level); end
        checks++; if (rd_almost_empty !== 1'b0) begin errors++; $display("FAIL ae_at5 got %0h exp 0", rd_almost_empty); end
        checks++; if (read_data !== mem[3]) begin errors++; $display("FAIL ae_rdata3 got %0h exp %0h", read_data, mem[3]); end
        tick();
        checks++; if (rd_level !== PW'(4)) begin errors++; $display("FAIL ae_level4 got %0d exp 4", rd_level); end
        checks++; if (rd_almost_empty !== 1'b1) begin errors++; $display("FAIL ae_at4 got %0h exp 1", rd_almost_empty); end
        checks++; if (read_data !== mem[4]) begin errors++; $display("FAIL ae_rdata4 got %0h exp %0h", read_data, mem[4]); end
        repeat (4) tick();
        read_enable = 1'b0;
        checks++; if (rdempty !== 1'b1) begin errors++; $display("FAIL ae_drained got %0h exp 1", rdempty); end
        checks++; if (fifo_read_count !== PW'(9)) begin errors++; $display("FAIL ae_count got %0d exp 9", fifo_read_count); end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] held;
        bit            exp_gap;
        held = read_data;
        exp_gap = STICKY;
        read_enable = 1'b1; tick();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_first got %0h exp 1", underflow); end
        read_enable = 1'b0; tick();
        checks++; if (underflow !== exp_gap) begin errors++; $display("FAIL uf_gap1 got %0h exp %0h", underflow, exp_gap); end
        read_enable = 1'b1; tick();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_second got %0h exp 1", underflow); end
        read_enable = 1'b0; tick();
        checks++; if (underflow !== exp_gap) begin errors++; $display("FAIL uf_gap2 got %0h exp %0h", underflow, exp_gap); end
        checks++; if (fifo_read_count !== PW'(9)) begin errors++; $display("FAIL uf_count got %0d exp 9", fifo_read_count); end
        checks++; if (read_data !== held) begin errors++; $display("FAIL uf_rdata_hold got %0h exp %0h", read_data, held); end
        checks++; if (rptr_gray !== PW'(gray_of(9))) begin errors++; $display("FAIL uf_rptr got %0h exp %0h", rptr_gray, gray_of(9)); end
        sw_rst = 1'b1; wcount = 0; wptr_gray = '0;
        tick();
        sw_rst = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_cleared got %0h exp 0", underflow); end
        checks++; if (fifo_read_count !== '0) begin errors++; $display("FAIL uf_swrst_count got %0d exp 0", fifo_read_count); end
        repeat (3) tick();
        checks++; if (rdempty !== 1'b1) begin errors++; $display("FAIL uf_settle_empty got %0h exp 1", rdempty); end
    endtask

    task automatic test_wrap();
        int wr_left;
        int start;
        int cycles;
        int toggles;
        logic prev_msb;
        wr_left = 70; start = m_total; cycles = 0; toggles = 0;
        prev_msb = rptr_gray[PW-1];
        while ((wr_left > 0 || (m_total - start) < 70) && cycles < 3000) begin
            aempty_value = AW'($urandom_range(0, DEPTH - 1));
            read_enable = ((m_total - start) < 70) && ($urandom_range(0, 1) == 1);
            if (wr_left > 0 && ((wcount - m_rptr + PMOD) % PMOD) < DEPTH && $urandom_range(0, 1) == 1) begin
                push_write();
                wr_left--;
            end
            tick();
            cycles++;
            if (rptr_gray[PW-1] !== prev_msb) toggles++;
            prev_msb = rptr_gray[PW-1];
            checks++; if (read_data !== m_rdata) begin errors++; $display("FAIL wrap_rdata c%0d got %0h exp %0h", cycles, read_data, m_rdata); end
            checks++; if (rd_level !== PW'(m_level)) begin errors++; $display("FAIL wrap_level c%0d got %0d exp %0d", cycles, rd_level, m_level); end
            checks++; if (rdempty !== m_empty) begin errors++; $display("FAIL wrap_empty c%0d got %0h exp %0h", cycles, rdempty, m_empty); end
            checks++; if (rd_almost_empty !== m_aempty) begin errors++; $display("FAIL wrap_aempty c%0d got %0h exp %0h", cycles, rd_almost_empty, m_aempty); end
            checks++; if (underflow !== m_underflow) begin errors++; $display("FAIL wrap_underflow c%0d got %0h exp %0h", cycles, underflow, m_underflow); end
            checks++; if (fifo_read_count !== PW'(m_rptr)) begin errors++; $display("FAIL wrap_count c%0d got %0d exp %0d", cycles, fifo_read_count, m_rptr); end
            checks++; if (rptr_gray !== PW'(gray_of(m_rptr))) begin errors++; $display("FAIL wrap_rptr c%0d got %0h exp %0h", cycles, rptr_gray, gray_of(m_rptr)); end
            checks++; if (mem_raddr !== AW'(m_rptr % DEPTH)) begin errors++; $display("FAIL wrap_raddr c%0d got %0d exp %0d", cycles, mem_raddr, m_rptr % DEPTH); end
            checks++; if (int'(rd_level) > DEPTH) begin errors++; $display("FAIL wrap_level_max c%0d got %0d exp <=%0d", cycles, rd_level, DEPTH); end
        end
        read_enable = 1'b0;
        checks++; if (cycles >= 3000) begin errors++; $display("FAIL wrap_timeout got %0d cycles exp <3000", cycles); end
        repeat (3) tick();
        checks++; if (fifo_read_count !== PW'(6)) begin errors++; $display("FAIL wrap_final_count got %0d exp 6", fifo_read_count); end
        checks++; if (toggles !== 2) begin errors++; $display("FAIL wrap_msb_toggles got %0d exp 2", toggles); end
        checks++; if (rdempty !== 1'b1) begin errors++; $display("FAIL wrap_drained got %0h exp 1", rdempty); end
    endtask

    task automatic test_sw_rst_mid_read();
        aempty_value = 5'd4;
        repeat (10) begin push_write(); tick(); end
        repeat (3) tick();
        checks++; if (rd_level !== PW'(10)) begin errors++; $display("FAIL swr_level10 got %0d exp 10", rd_level); end
        read_enable = 1'b1; sw_rst = 1'b1; wcount = 0; wptr_gray = '0;
        tick();
        read_enable = 1'b0; sw_rst = 1'b0;
        checks++; if (rd_level !== '0) begin errors++; $display("FAIL swr_level got %0d exp 0", rd_level); end
        checks++; if (fifo_read_count !== '0) begin errors++; $display("FAIL swr_count got %0d exp 0", fifo_read_count); end
        checks++; if (rdempty !== 1'b1) begin errors++; $display("FAIL swr_empty got %0h exp 1", rdempty); end
        checks++; if (read_data !== '0) begin errors++; $display("FAIL swr_rdata got %0h exp 0", read_data); end
        checks++; if (rptr_gray !== '0) begin errors++; $display("FAIL swr_rptr got %0h exp 0", rptr_gray); end
        checks++; if (rd_almost_empty !== 1'b1) begin errors++; $display("FAIL swr_aempty got %0h exp 1", rd_almost_empty); end
        repeat (3) tick();
        checks++; if (rdempty !== 1'b1) begin errors++; $display("FAIL swr_settle_empty got %0h exp 1", rdempty); end
    endtask

    task automatic test_hw_rst_async();
        repeat (5) begin push_write(); tick(); end
        repeat (3) tick();
        read_enable = 1'b1; repeat (2) tick(); read_enable = 1'b0;
        checks++; if (fifo_read_count !== PW'(2)) begin errors++; $display("FAIL hwr_pre_count got %0d exp 2", fifo_read_count); end
        #2;
        hw_rst_n = 1'b0; wcount = 0; wptr_gray = '0;
        #1;
        checks++; if (rdempty !== 1'b1) begin errors++; $display("FAIL hwr_empty got %0h exp 1", rdempty); end
        checks++; if (rd_almost_empty !== 1'b1) begin errors++; $display("FAIL hwr_aempty got %0h exp 1", rd_almost_empty); end
        checks++; if (rd_level !== '0) begin errors++; $display("FAIL hwr_level got %0d exp 0", rd_level); end
        checks++; if (fifo_read_count !== '0) begin errors++; $display("FAIL hwr_count got %0d exp 0", fifo_read_count); end
        checks++; if (read_data !== '0) begin errors++; $display("FAIL hwr_rdata got %0h exp 0", read_data); end
        checks++; if (rptr_gray !== '0) begin errors++; $display("FAIL hwr_rptr got %0h exp 0", rptr_gray); end
        checks++; if (mem_raddr !== '0) begin errors++; $display("FAIL hwr_raddr got %0d exp 0", mem_raddr); end
        @(negedge rclk);
        hw_rst_n = 1'b1;
        repeat (3) tick();
        push_write(); tick();
        repeat (3) tick();
        checks++; if (rdempty !== 1'b0) begin errors++; $display("FAIL hwr_post_empty got %0h exp 0", rdempty); end
        read_enable = 1'b1; tick(); read_enable = 1'b0;
        checks++; if (read_data !== mem[0]) begin errors++; $display("FAIL hwr_post_rdata got %0h exp %0h", read_data, mem[0]); end
        checks++; if (fifo_read_count !== PW'(1)) begin errors++; $display("FAIL hwr_post_count got %0d exp 1", fifo_read_count); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_read();
        test_almost_empty();
        test_underflow();
        test_wrap();
        test_sw_rst_mid_read();
        test_hw_rst_async();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
